// File: rtl/mvm_pkg.sv
// Shared types and width helpers for the matrix-vector-multiply control path.
package mvm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadX,
        StCompute,
        StDrain,
        StDone,
        StOutput
    } mvm_state_e;

    // Bit width able to index 0..n-1; a single-entry range still gets one bit.
    function automatic int unsigned clog2w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mvm_rc_counter.sv
// Two-level row/column counter: inner wraps at InnerMax-1, outer wraps at a run-time limit.
module mvm_rc_counter
    import mvm_pkg::*;
#(
    parameter int unsigned OuterMax = 20,
    parameter int unsigned InnerMax = 20,
    localparam int unsigned OW = clog2w(OuterMax),
    localparam int unsigned IW = clog2w(InnerMax)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [OW-1:0] outer_lim_i,
    output logic [OW-1:0] outer_o,
    output logic [IW-1:0] inner_o,
    output logic          last_o
);

    logic [OW-1:0] outer_q, outer_d;
    logic [IW-1:0] inner_q, inner_d;
    logic          inner_wrap;

    assign inner_wrap = (inner_q == IW'(InnerMax - 1));
    assign last_o     = inner_wrap && (outer_q == outer_lim_i);
    assign outer_o    = outer_q;
    assign inner_o    = inner_q;

    always_comb begin
        outer_d = outer_q;
        inner_d = inner_q;
        if (clr_i) begin
            outer_d = '0;
            inner_d = '0;
        end else if (en_i) begin
            if (inner_wrap) begin
                inner_d = '0;
                outer_d = (outer_q == outer_lim_i) ? '0 : outer_q + 1'b1;
            end else begin
                inner_d = inner_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            outer_q <= '0;
            inner_q <= '0;
        end else begin
            outer_q <= outer_d;
            inner_q <= inner_d;
        end
    end

endmodule

// File: rtl/mvm_ctrl.sv
// Control FSM for y = A*x: load sequencing, MAC issue/alignment, result writes and readout.
module mvm_ctrl
    import mvm_pkg::*;
#(
    parameter int unsigned M      = 20,
    parameter int unsigned N      = 20,
    parameter int unsigned P      = 1,
    parameter int unsigned RD_LAT = 1,
    localparam int unsigned AW = clog2w(M * N / P),
    localparam int unsigned XW = clog2w(N),
    localparam int unsigned GW = clog2w(M / P),
    localparam int unsigned RW = clog2w(M)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_matrix_i,
    input  logic          load_vector_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic [P-1:0]  a_we_o,
    output logic [AW-1:0] a_addr_o,
    output logic          x_we_o,
    output logic [XW-1:0] x_addr_o,
    output logic          mac_clr_o,
    output logic          mac_en_o,
    output logic          res_we_o,
    output logic [GW-1:0] res_grp_o,
    output logic          done_o,
    output logic [RW-1:0] out_rd_addr_o,
    output logic          out_valid_o
);

    localparam int unsigned G = M / P;

    mvm_state_e        st_q;
    logic              cnt_en, cnt_last, issue;
    logic [RW-1:0]     cnt_outer, cnt_lim;
    logic [XW-1:0]     cnt_inner;
    logic [RD_LAT-1:0] en_sr_q, clr_sr_q;
    logic [RD_LAT:0]   end_sr_q;
    logic [GW-1:0]     res_cnt_q;
    logic [RW-1:0]     out_addr_q;
    logic              done_q, out_valid_q;
    logic [31:0]       row_blk;

    // Outer count is the matrix row while loading and the row group while computing.
    always_comb begin
        cnt_en = (st_q == StLoadA) || (st_q == StLoadX) || (st_q == StCompute);
        if (st_q == StLoadA) begin
            cnt_lim = RW'(M - 1);
        end else if (st_q == StCompute) begin
            cnt_lim = RW'(G - 1);
        end else begin
            cnt_lim = '0;
        end
    end

    mvm_rc_counter #(
        .OuterMax (M),
        .InnerMax (N)
    ) u_rc_counter (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (!cnt_en),
        .en_i        (cnt_en),
        .outer_lim_i (cnt_lim),
        .outer_o     (cnt_outer),
        .inner_o     (cnt_inner),
        .last_o      (cnt_last)
    );

    always_comb begin
        row_blk = 32'(cnt_outer);
        if (st_q == StLoadA) begin
            row_blk = row_blk / P;
        end
    end

    assign issue         = (st_q == StCompute);
    assign busy_o        = (st_q != StIdle);
    assign a_we_o        = (st_q == StLoadA) ? P'(1) << (cnt_outer % P) : '0;
    assign a_addr_o      = ((st_q == StLoadA) || issue) ?
                           AW'(row_blk * N + 32'(cnt_inner)) : '0;
    assign x_we_o        = (st_q == StLoadX);
    assign x_addr_o      = ((st_q == StLoadX) || issue) ? cnt_inner : '0;
    assign mac_en_o      = en_sr_q[RD_LAT-1];
    assign mac_clr_o     = clr_sr_q[RD_LAT-1];
    assign res_we_o      = end_sr_q[RD_LAT];
    assign res_grp_o     = res_cnt_q;
    assign done_o        = done_q;
    assign out_rd_addr_o = out_addr_q;
    assign out_valid_o   = out_valid_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            st_q        <= StIdle;
            en_sr_q     <= '0;
            clr_sr_q    <= '0;
            end_sr_q    <= '0;
            res_cnt_q   <= '0;
            out_addr_q  <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // The result write trails the group's last MAC by one cycle.
            en_sr_q[0]  <= issue;
            clr_sr_q[0] <= issue && (cnt_inner == '0);
            end_sr_q[0] <= issue && (cnt_inner == XW'(N - 1));
            for (int i = 1; i < RD_LAT; i++) begin
                en_sr_q[i]  <= en_sr_q[i-1];
                clr_sr_q[i] <= clr_sr_q[i-1];
            end
            for (int i = 1; i <= RD_LAT; i++) begin
                end_sr_q[i] <= end_sr_q[i-1];
            end
            if (res_we_o) begin
                res_cnt_q <= (res_cnt_q == GW'(G - 1)) ? '0 : res_cnt_q + 1'b1;
            end
            done_q      <= 1'b0;
            out_valid_q <= (st_q == StDone) || (st_q == StOutput);

            unique case (st_q)
                StIdle: begin
                    if (load_matrix_i) begin
                        st_q <= StLoadA;
                    end else if (load_vector_i) begin
                        st_q <= StLoadX;
                    end else if (start_i) begin
                        st_q <= StCompute;
                    end
                end
                StLoadA, StLoadX: begin
                    if (cnt_last) st_q <= StIdle;
                end
                StCompute: begin
                    if (cnt_last) st_q <= StDrain;
                end
                StDrain: begin
                    if (res_we_o && (res_cnt_q == GW'(G - 1))) begin
                        st_q   <= StDone;
                        done_q <= 1'b1;
                    end
                end
                StDone, StOutput: begin
                    if (out_addr_q == RW'(M - 1)) begin
                        st_q       <= StIdle;
                        out_addr_q <= '0;
                    end else begin
                        st_q       <= StOutput;
                        out_addr_q <= out_addr_q + 1'b1;
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_ctrl.sv
// Randomised bench for mvm_ctrl: two instances (P=1 and P=4) against a cycle-offset model.
module tb_mvm_ctrl;

    localparam int M = 20;
    localparam int N = 20;
    localparam int RD_LAT = 1;
    localparam int IDLE = 0, LDA = 1, LDX = 2, CMP = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lm = 1'b0, lv = 1'b0, st = 1'b0;

    logic       busy0, x_we0, mac_clr0, mac_en0, res_we0, done0, out_valid0;
    logic [0:0] a_we0;
    logic [8:0] a_addr0;
    logic [4:0] x_addr0, res_grp0, out_rd0;

    logic       busy1, x_we1, mac_clr1, mac_en1, res_we1, done1, out_valid1;
    logic [3:0] a_we1;
    logic [6:0] a_addr1;
    logic [4:0] x_addr1, out_rd1;
    logic [2:0] res_grp1;

    int n_checks = 0;
    int n_fail = 0;
    int mode[2];
    int tc[2];
    bit rst_seen[2];

    always #5 clk = ~clk;

    mvm_ctrl #(.M(M), .N(N), .P(1), .RD_LAT(RD_LAT)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .load_matrix_i(lm), .load_vector_i(lv), .start_i(st),
        .busy_o(busy0), .a_we_o(a_we0), .a_addr_o(a_addr0), .x_we_o(x_we0), .x_addr_o(x_addr0),
        .mac_clr_o(mac_clr0), .mac_en_o(mac_en0), .res_we_o(res_we0), .res_grp_o(res_grp0),
        .done_o(done0), .out_rd_addr_o(out_rd0), .out_valid_o(out_valid0)
    );

    mvm_ctrl #(.M(M), .N(N), .P(4), .RD_LAT(RD_LAT)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .load_matrix_i(lm), .load_vector_i(lv), .start_i(st),
        .busy_o(busy1), .a_we_o(a_we1), .a_addr_o(a_addr1), .x_we_o(x_we1), .x_addr_o(x_addr1),
        .mac_clr_o(mac_clr1), .mac_en_o(mac_en1), .res_we_o(res_we1), .res_grp_o(res_grp1),
        .done_o(done1), .out_rd_addr_o(out_rd1), .out_valid_o(out_valid1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int p_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int end_of(input int d);
        int dd;
        dd = (M / p_of(d)) * N + RD_LAT + 2;
        case (mode[d])
            LDA:     return M * N + 1;
            LDX:     return N + 1;
            CMP:     return dd + M;
            default: return 0;
        endcase
    endfunction

    function automatic bit accepting(input int d);
        return (mode[d] == IDLE) || (tc[d] >= end_of(d));
    endfunction

    // Expected outputs from the offset t since the accepted command.
    task automatic check_dut(input int d, input logic [31:0] busy, a_we, a_addr, x_we, x_addr,
                             mac_clr, mac_en, res_we, res_grp, done, out_rd, out_valid);
        int p, g, dd, t, e, u, r;
        int eb, eaw, eaa, exw, exa, ec, em, er, eg, edn, eo, ev;
        bit ca, cx, cg, co;
        string pre;
        p = p_of(d); g = M / p; dd = g * N + RD_LAT + 2; t = tc[d];
        eb = 0; eaw = 0; eaa = 0; exw = 0; exa = 0; ec = 0; em = 0; er = 0; eg = 0;
        edn = 0; eo = 0; ev = 0;
        ca = rst_seen[d]; cx = rst_seen[d]; cg = rst_seen[d]; co = rst_seen[d];
        pre = $sformatf("d%0d.m%0d.t%0d.", d, mode[d], t);
        if (mode[d] == LDA && t >= 1 && t <= M * N) begin
            e = t - 1; eb = 1; ca = 1;
            eaw = 1 << ((e / N) % p);
            eaa = ((e / N) / p) * N + e % N;
        end
        if (mode[d] == LDX && t >= 1 && t <= N) begin
            eb = 1; exw = 1; cx = 1; exa = t - 1;
        end
        if (mode[d] == CMP) begin
            eb = (t >= 1 && t < dd + M) ? 1 : 0;
            if (t >= 1 && t <= g * N) begin
                ca = 1; cx = 1; eaa = t - 1; exa = (t - 1) % N;
            end
            u = t - RD_LAT;
            if (u >= 1 && u <= g * N) begin
                em = 1; ec = ((u - 1) % N == 0) ? 1 : 0;
            end
            r = t - RD_LAT - 1;
            if (r >= N && r % N == 0 && r / N <= g) begin
                er = 1; cg = 1; eg = r / N - 1;
            end
            edn = (t == dd) ? 1 : 0;
            if (t >= dd && t < dd + M) begin
                co = 1; eo = t - dd;
            end
            ev = (t > dd && t <= dd + M) ? 1 : 0;
        end
        check_eq({pre, "busy"}, busy, 32'(eb));
        check_eq({pre, "a_we"}, a_we, 32'(eaw));
        check_eq({pre, "x_we"}, x_we, 32'(exw));
        check_eq({pre, "mac_en"}, mac_en, 32'(em));
        check_eq({pre, "mac_clr"}, mac_clr, 32'(ec));
        check_eq({pre, "res_we"}, res_we, 32'(er));
        check_eq({pre, "done"}, done, 32'(edn));
        check_eq({pre, "out_valid"}, out_valid, 32'(ev));
        if (ca) check_eq({pre, "a_addr"}, a_addr, 32'(eaa));
        if (cx) check_eq({pre, "x_addr"}, x_addr, 32'(exa));
        if (cg) check_eq({pre, "res_grp"}, res_grp, 32'(eg));
        if (co) check_eq({pre, "out_rd_addr"}, out_rd, 32'(eo));
    endtask

    task automatic advance(input int d, input bit l_m, l_v, s, r);
        if (!r) begin
            mode[d] = IDLE; tc[d] = 0; rst_seen[d] = 1'b1;
        end else if (accepting(d) && (l_m || l_v || s)) begin
            mode[d] = l_m ? LDA : (l_v ? LDX : CMP);
            tc[d] = 1; rst_seen[d] = 1'b0;
        end else if (mode[d] != IDLE) begin
            tc[d]++;
        end
    endtask

    task automatic drive(input bit l_m, l_v, s, r);
        lm = l_m; lv = l_v; st = s; rst_n = r;
        @(negedge clk);
        check_dut(0, 32'(busy0), 32'(a_we0), 32'(a_addr0), 32'(x_we0), 32'(x_addr0),
                  32'(mac_clr0), 32'(mac_en0), 32'(res_we0), 32'(res_grp0), 32'(done0),
                  32'(out_rd0), 32'(out_valid0));
        check_dut(1, 32'(busy1), 32'(a_we1), 32'(a_addr1), 32'(x_we1), 32'(x_addr1),
                  32'(mac_clr1), 32'(mac_en1), 32'(res_we1), 32'(res_grp1), 32'(done1),
                  32'(out_rd1), 32'(out_valid1));
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) advance(d, l_m, l_v, s, r);
    endtask

    task automatic run_busy(input bit strays);
        int n;
        logic [2:0] c;
        n = 0;
        while (!accepting(0) && n < 3000) begin
            c = (strays && $urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            drive(c[2], c[1], c[0], 1'b1);
            n++;
        end
        if (n >= 3000) check_eq("run_bound", 32'(n), 32'(0));
    endtask

    initial begin
        logic [2:0] cmd;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            mode[d] = IDLE; tc[d] = 0; rst_seen[d] = 1'b1;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        // loadMatrix and start together: matrix load wins
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        run_busy(1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        run_busy(1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        run_busy(1'b0);
        // start while loading is dropped
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        run_busy(1'b0);
        // reset in compute cycle 100, then a clean compute
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        while (tc[0] < 100) drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        run_busy(1'b0);
        repeat (12) begin
            repeat ($urandom_range(0, 3)) drive(1'b0, 1'b0, 1'b0, 1'b1);
            cmd = 3'($urandom_range(1, 7));
            drive(cmd[2], cmd[1], cmd[0], 1'b1);
            run_busy(1'b1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
